// File: rtl/count_game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : count_game_pkg                                             |
// | Purpose : Shared state encodings and LFSR constants for the LED      |
// |           counting game controller.                                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package count_game_pkg;

    // State encoding, 3 bits wide; the display drivers decode these values.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GREET    = 3'd1;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_CHECK    = 3'd3;
    localparam logic [2:0] ST_FEEDBACK = 3'd4;
    localparam logic [2:0] ST_VICTORY  = 3'd5;
    localparam logic [2:0] ST_FAIL     = 3'd6;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit at bit
    // indices 0,2,3,5 of the register.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_game_ctrl_popcount.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : popcount_tree                                              |
// | Purpose : Combinational population count built as a balanced adder  |
// |           tree over a power-of-two padded input.                     |
// | Ports   : i_bits  [W-1:0]           input vector                     |
// |           o_count [$clog2(W+1)-1:0] number of set bits               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module popcount_tree #(
    parameter int W = 16
) (
    input  logic [W-1:0]            i_bits,
    output logic [$clog2(W+1)-1:0]  o_count
);

    localparam int OW = $clog2(W + 1);
    localparam int P  = 1 << $clog2(W);

    logic [P-1:0] w_padded;

    assign w_padded = P'(i_bits);

    // Each pass of the outer loop is one tree level: pairs of partial sums
    // are folded into the lower half of the array until one sum remains.
    always_comb begin : p_tree
        logic [OW-1:0] w_node [P];
        for (int i = 0; i < P; i++) begin
            w_node[i] = OW'(w_padded[i]);
        end
        for (int span = P / 2; span >= 1; span = span / 2) begin
            for (int j = 0; j < span; j++) begin
                w_node[j] = w_node[2*j] + w_node[2*j+1];
            end
        end
        o_count = w_node[0];
    end

endmodule
`default_nettype wire

// File: rtl/count_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : count_game_ctrl                                            |
// | Purpose : Round-based controller for the LED counting game. Shows a  |
// |           pseudo-random LED pattern, takes the player's lit-LED      |
// |           count from the switches, and keeps rounds, a per-round     |
// |           countdown, lives and score.                                |
// | Ports   : clk, rst (async, active high), en (game enable level),     |
// |           start / sure (one-cycle debounced pulses), sw (answer);    |
// |           state, round, score, lives, sec_left, led, ok, beep, win,  |
// |           lose - all registered.                                     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module count_game_ctrl
    import count_game_pkg::*;
#(
    parameter int N_ROUNDS  = 3,
    parameter int SW_W      = 7,
    parameter int LED_W     = 16,
    parameter int TICK_DIV  = 100_000_000,
    parameter int ROUND_SEC = 10,
    parameter int LIVES     = 3,
    parameter int FB_CYC    = 50_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            start,
    input  logic                            sure,
    input  logic [SW_W-1:0]                 sw,
    output logic [2:0]                      state,
    output logic [$clog2(N_ROUNDS+1)-1:0]   round,
    output logic [$clog2(N_ROUNDS+1)-1:0]   score,
    output logic [2:0]                      lives,
    output logic [7:0]                      sec_left,
    output logic [LED_W-1:0]                led,
    output logic                            ok,
    output logic                            beep,
    output logic                            win,
    output logic                            lose
);

    localparam int RW   = $clog2(N_ROUNDS + 1);
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FB_W = (FB_CYC > 1) ? $clog2(FB_CYC) : 1;
    localparam int PC_W = $clog2(LED_W + 1);

    localparam logic [PS_W-1:0]  c_ps_last    = PS_W'(TICK_DIV - 1);
    localparam logic [FB_W-1:0]  c_fb_last    = FB_W'(FB_CYC - 1);
    localparam logic [7:0]       c_sec_init   = 8'(ROUND_SEC);
    localparam logic [2:0]       c_lives_init = 3'(LIVES);
    localparam logic [RW-1:0]    c_score_max  = RW'(N_ROUNDS);
    localparam logic [RW-1:0]    c_last_round = RW'(N_ROUNDS - 1);
    localparam logic [LED_W-1:0] c_leds_on    = {LED_W{1'b1}};

    logic [2:0]       r_state;
    logic [RW-1:0]    r_round;
    logic [RW-1:0]    r_score;
    logic [2:0]       r_lives;
    logic [7:0]       r_sec_left;
    logic [LED_W-1:0] r_led;
    logic             r_ok;
    logic             r_beep;
    logic             r_win;
    logic             r_lose;
    logic [15:0]      r_lfsr;
    logic [LED_W-1:0] r_pattern;
    logic [SW_W-1:0]  r_sw_q;
    logic             r_timeout;
    logic [PS_W-1:0]  r_ps;
    logic [FB_W-1:0]  r_fb_cnt;

    logic [LED_W-1:0] w_new_pattern;
    logic [PC_W-1:0]  w_popcount;
    logic [SW_W-1:0]  w_expected;
    logic             w_ok;

    // A blank pattern would make the round unanswerable on the display,
    // so it is replaced by a single lit LED.
    assign w_new_pattern = (r_lfsr[LED_W-1:0] == '0) ? LED_W'(1) : r_lfsr[LED_W-1:0];

    popcount_tree #(
        .W (LED_W)
    ) u_popcount (
        .i_bits  (r_pattern),
        .o_count (w_popcount)
    );

    assign w_expected = SW_W'(w_popcount);
    // A timed-out round is always wrong, whatever the switches held.
    assign w_ok       = (r_sw_q == w_expected) && !r_timeout;

    // Free-running pattern source; keeps stepping regardless of state or en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_round    <= '0;
            r_score    <= '0;
            r_lives    <= c_lives_init;
            r_sec_left <= c_sec_init;
            r_led      <= '0;
            r_ok       <= 1'b0;
            r_beep     <= 1'b0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_pattern  <= '0;
            r_sw_q     <= '0;
            r_timeout  <= 1'b0;
            r_ps       <= '0;
            r_fb_cnt   <= '0;
        end else if (!en) begin
            // Disabling the game abandons it from any state.
            r_state    <= ST_IDLE;
            r_round    <= '0;
            r_score    <= '0;
            r_lives    <= c_lives_init;
            r_sec_left <= c_sec_init;
            r_led      <= '0;
            r_ok       <= 1'b0;
            r_beep     <= 1'b0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_timeout  <= 1'b0;
            r_ps       <= '0;
            r_fb_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_GREET;
                    r_led   <= c_leds_on;
                end

                ST_GREET: begin
                    if (start) begin
                        r_round    <= '0;
                        r_score    <= '0;
                        r_lives    <= c_lives_init;
                        r_pattern  <= w_new_pattern;
                        r_led      <= w_new_pattern;
                        r_sec_left <= c_sec_init;
                        r_ps       <= '0;
                        r_timeout  <= 1'b0;
                        r_state    <= ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    // sure takes priority over a simultaneous countdown expiry.
                    if (sure) begin
                        r_sw_q    <= sw;
                        r_timeout <= 1'b0;
                        r_state   <= ST_CHECK;
                    end else if (r_ps == c_ps_last) begin
                        r_ps <= '0;
                        if (r_sec_left == 8'd1) begin
                            r_sec_left <= 8'd0;
                            r_timeout  <= 1'b1;
                            r_state    <= ST_CHECK;
                        end else begin
                            r_sec_left <= r_sec_left - 8'd1;
                        end
                    end else begin
                        r_ps <= r_ps + PS_W'(1);
                    end
                end

                ST_CHECK: begin
                    r_ok <= w_ok;
                    if (w_ok) begin
                        if (r_score != c_score_max) begin
                            r_score <= r_score + RW'(1);
                        end
                    end else if (r_lives != 3'd0) begin
                        r_lives <= r_lives - 3'd1;
                    end
                    r_beep   <= ~w_ok;
                    r_fb_cnt <= '0;
                    r_state  <= ST_FEEDBACK;
                end

                ST_FEEDBACK: begin
                    if (r_fb_cnt == c_fb_last) begin
                        if (r_lives == 3'd0) begin
                            r_led   <= '0;
                            r_lose  <= 1'b1;
                            r_beep  <= 1'b0;
                            r_state <= ST_FAIL;
                        end else if (r_ok && (r_round == c_last_round)) begin
                            // The victory fanfare reuses the feedback counter.
                            r_led    <= c_leds_on;
                            r_win    <= 1'b1;
                            r_beep   <= 1'b1;
                            r_fb_cnt <= '0;
                            r_state  <= ST_VICTORY;
                        end else begin
                            if (r_ok) begin
                                r_round <= r_round + RW'(1);
                            end
                            r_beep     <= 1'b0;
                            r_pattern  <= w_new_pattern;
                            r_led      <= w_new_pattern;
                            r_sec_left <= c_sec_init;
                            r_ps       <= '0;
                            r_timeout  <= 1'b0;
                            r_state    <= ST_PLAY;
                        end
                    end else begin
                        r_fb_cnt <= r_fb_cnt + FB_W'(1);
                    end
                end

                ST_VICTORY: begin
                    if (start) begin
                        r_led   <= c_leds_on;
                        r_win   <= 1'b0;
                        r_beep  <= 1'b0;
                        r_state <= ST_GREET;
                    end else if (r_fb_cnt == c_fb_last) begin
                        r_beep <= 1'b0;
                    end else begin
                        r_fb_cnt <= r_fb_cnt + FB_W'(1);
                    end
                end

                ST_FAIL: begin
                    if (start) begin
                        r_led   <= c_leds_on;
                        r_lose  <= 1'b0;
                        r_state <= ST_GREET;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_led   <= '0;
                end
            endcase
        end
    end

    assign state    = r_state;
    assign round    = r_round;
    assign score    = r_score;
    assign lives    = r_lives;
    assign sec_left = r_sec_left;
    assign led      = r_led;
    assign ok       = r_ok;
    assign beep     = r_beep;
    assign win      = r_win;
    assign lose     = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_count_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_count_game_ctrl                                         |
// | Purpose : Self-checking bench for count_game_ctrl with short timing  |
// |           parameters; expected round results are queued by the      |
// |           stimulus and checked when FEEDBACK is entered.             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_count_game_ctrl;
    import count_game_pkg::*;

    localparam int N_ROUNDS  = 3;
    localparam int SW_W      = 7;
    localparam int LED_W     = 16;
    localparam int TICK_DIV  = 4;
    localparam int ROUND_SEC = 3;
    localparam int LIVES     = 2;
    localparam int FB_CYC    = 5;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             en    = 1'b0;
    logic             start = 1'b0;
    logic             sure  = 1'b0;
    logic [SW_W-1:0]  sw    = '0;
    logic [2:0]       state;
    logic [1:0]       round;
    logic [1:0]       score;
    logic [2:0]       lives;
    logic [7:0]       sec_left;
    logic [LED_W-1:0] led;
    logic             ok;
    logic             beep;
    logic             win;
    logic             lose;

    count_game_ctrl #(
        .N_ROUNDS  (N_ROUNDS),
        .SW_W      (SW_W),
        .LED_W     (LED_W),
        .TICK_DIV  (TICK_DIV),
        .ROUND_SEC (ROUND_SEC),
        .LIVES     (LIVES),
        .FB_CYC    (FB_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .sure     (sure),
        .sw       (sw),
        .state    (state),
        .round    (round),
        .score    (score),
        .lives    (lives),
        .sec_left (sec_left),
        .led      (led),
        .ok       (ok),
        .beep     (beep),
        .win      (win),
        .lose     (lose)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       ok;
        logic [1:0] score;
        logic [2:0] lives;
        logic [1:0] round;
    } exp_t;

    exp_t q_exp[$];

    // Reference pattern generator: taps 16,14,13,11 of a right-shifting
    // register are bits 0,2,3,5.
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    logic [15:0] m_pattern = 16'd0;
    logic [2:0]  trk_prev  = 3'd0;
    logic [2:0]  mon_prev  = 3'd0;

    logic [1:0]  e_score;
    logic [2:0]  e_lives;
    logic [1:0]  e_round;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

    // The pattern for a round is the generator value just before the edge
    // that enters PLAY.
    always @(posedge clk) begin
        #1;
        if (state == ST_PLAY && trk_prev != ST_PLAY) begin
            m_pattern = (m_prev == 16'd0) ? 16'd1 : m_prev;
        end
        trk_prev = state;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a round result is presented on FEEDBACK entry.
    always @(negedge clk) begin
        exp_t e;
        if (state == ST_FEEDBACK && mon_prev != ST_FEEDBACK) begin
            if (q_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fb_unexpected: got FEEDBACK entry expected none at %0t", $time);
            end else begin
                e = q_exp.pop_front();
                check("fb_ok",    ok,    e.ok);
                check("fb_score", score, e.score);
                check("fb_lives", lives, e.lives);
                check("fb_round", round, e.round);
                check("fb_beep",  beep,  !e.ok);
                check("fb_led",   led,   m_pattern);
            end
        end
        mon_prev = state;
    end

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (state !== s && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, state, s);
    endtask

    task automatic new_game();
        e_score = 2'd0;
        e_lives = 3'(LIVES);
        e_round = 2'd0;
    endtask

    task automatic push_exp(input logic good);
        exp_t e;
        if (good) begin
            if (e_score != 2'(N_ROUNDS)) e_score = e_score + 2'd1;
        end else if (e_lives != 3'd0) begin
            e_lives = e_lives - 3'd1;
        end
        e.ok    = good;
        e.score = e_score;
        e.lives = e_lives;
        e.round = e_round;
        q_exp.push_back(e);
        if (good && e_lives != 3'd0 && e_round != 2'(N_ROUNDS - 1)) e_round = e_round + 2'd1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic answer(input logic good);
        int cnt;
        wait_state(ST_PLAY, "play_entry");
        check("play_led",   led,   m_pattern);
        check("play_round", round, e_round);
        cnt = $countones(m_pattern);
        sw  = good ? SW_W'(cnt) : SW_W'(cnt + 1);
        push_exp(good);
        sure = 1'b1;
        @(negedge clk);
        sure = 1'b0;
    endtask

    initial begin
        int n_beep;
        new_game();
        repeat (2) @(negedge clk);
        check("rst_state", state,    ST_IDLE);
        check("rst_round", round,    0);
        check("rst_score", score,    0);
        check("rst_lives", lives,    LIVES);
        check("rst_sec",   sec_left, ROUND_SEC);
        check("rst_led",   led,      0);
        check("rst_flags", {ok, beep, win, lose}, 0);

        // Game 1: two correct answers, then a correct answer on the timeout edge.
        rst = 1'b0;
        en  = 1'b1;
        wait_state(ST_GREET, "greet");
        check("greet_led", led, 16'hFFFF);
        pulse_start();
        answer(1'b1);
        answer(1'b1);
        wait_state(ST_PLAY, "play_r2");
        check("r2_sec_init", sec_left, 3);
        sw = SW_W'($countones(m_pattern));
        push_exp(1'b1);
        repeat (11) @(negedge clk);
        check("r2_sec_last", sec_left, 1);
        sure = 1'b1;
        @(negedge clk);
        sure = 1'b0;
        check("r2_sure_wins", state, ST_CHECK);
        wait_state(ST_VICTORY, "victory");
        check("vic_win",  win,  1);
        check("vic_led",  led,  16'hFFFF);
        check("vic_lose", lose, 0);
        n_beep = 0;
        for (int i = 0; i < 10; i++) begin
            if (beep) n_beep++;
            @(negedge clk);
        end
        check("vic_beep_cycles", n_beep, FB_CYC);
        pulse_start();
        check("vic_to_greet", state, ST_GREET);
        check("greet_win_clr", win, 0);

        // Game 2: two wrong answers exhaust the lives.
        new_game();
        pulse_start();
        answer(1'b0);
        answer(1'b0);
        wait_state(ST_FAIL, "fail");
        check("fail_lose",  lose,  1);
        check("fail_led",   led,   0);
        check("fail_beep",  beep,  0);
        check("fail_lives", lives, 0);
        pulse_start();
        check("fail_to_greet", state, ST_GREET);

        // Game 3: countdown expiry with start ignored in PLAY.
        new_game();
        pulse_start();
        wait_state(ST_PLAY, "play_to");
        check("to_sec3a", sec_left, 3);
        push_exp(1'b0);
        start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 3)  check("to_sec3b", sec_left, 3);
            if (i == 4)  check("to_sec2",  sec_left, 2);
            if (i == 8)  check("to_sec1",  sec_left, 1);
            if (i == 11) check("to_still_play", state, ST_PLAY);
            if (i == 12) begin
                check("to_sec0",  sec_left, 0);
                check("to_check", state,    ST_CHECK);
            end
        end
        wait_state(ST_PLAY, "replay");
        check("replay_round", round,    e_round);
        check("replay_lives", lives,    e_lives);
        check("replay_sec",   sec_left, 3);

        // Asynchronous reset in the middle of PLAY.
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_state", state, ST_IDLE);
        check("arst_led",   led,   0);
        check("arst_lives", lives, LIVES);
        @(negedge clk);
        rst = 1'b0;

        // Dropping en during FEEDBACK abandons the game.
        new_game();
        wait_state(ST_GREET, "greet2");
        pulse_start();
        answer(1'b1);
        wait_state(ST_FEEDBACK, "fb_en");
        en = 1'b0;
        @(negedge clk);
        check("en_state", state, ST_IDLE);
        check("en_score", score, 0);
        check("en_round", round, 0);
        check("en_lives", lives, LIVES);
        check("en_led",   led,   0);

        check("queue_drained", q_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before 1000000");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
